// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the fetch-to-S1 issue controller: instruction
// field positions, the NOP encoding and the issue FSM state encoding.
package pipe_ctrl_pkg;

    localparam int INSTR_W     = 32;
    localparam int RD_LSB      = 21;
    localparam int RS1_LSB     = 16;
    localparam int RS2_LSB     = 11;
    localparam int DATASRC_BIT = 29;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STALL   = 2'd1,
        ST_HALTING = 2'd2,
        ST_HALTED  = 2'd3
    } issue_state_e;

    // rs2 is only a real source when the second operand is not an immediate.
    function automatic logic uses_rs2(input logic [INSTR_W-1:0] instr);
        return ~instr[DATASRC_BIT];
    endfunction

endpackage

// File: rtl/pipe_issue_if.sv
// Fetch-side / S1-side signal bundle of the issue controller. The master
// is the fetch/test side, the slave is the controller itself.
interface pipe_issue_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      InstrIn;
    logic             instr_valid;
    logic             instr_we;
    logic             halt_req;
    logic             instr_ready;
    logic [31:0]      s1_instr;
    logic             s1_write_enable;
    logic [CNT_W-1:0] stall_count;
    logic             halted;

    modport master (
        output InstrIn, instr_valid, instr_we, halt_req,
        input  instr_ready, s1_instr, s1_write_enable, stall_count, halted
    );

    modport slave (
        input  InstrIn, instr_valid, instr_we, halt_req,
        output instr_ready, s1_instr, s1_write_enable, stall_count, halted
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker: a DEPTH-deep shift register of {v, rd}
// entries, one per pipe stage ahead of the regfile write, compared against
// the candidate's source registers every cycle.
module hazard_scoreboard #(
    parameter int DEPTH  = 3,
    parameter int RSEL_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RSEL_W-1:0] rs1_i,
    input  logic [RSEL_W-1:0] rs2_i,
    input  logic              use_rs2_i,
    input  logic              push_v_i,
    input  logic [RSEL_W-1:0] push_rd_i,
    output logic              hazard_o,
    output logic              empty_o
);

    logic [DEPTH-1:0]             sb_v_q;
    logic [DEPTH-1:0][RSEL_W-1:0] sb_rd_q;
    logic [DEPTH-1:0]             hit;

    // Advance every entry one stage per cycle; a bubble enters as v=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_v_q  <= '0;
            sb_rd_q <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                sb_v_q[i]  <= sb_v_q[i-1];
                sb_rd_q[i] <= sb_rd_q[i-1];
            end
            sb_v_q[0]  <= push_v_i;
            sb_rd_q[0] <= push_rd_i;
        end
    end

    // Per-entry RAW match; register 0 is hardwired and never a dependency.
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sb_v_q[i] && (sb_rd_q[i] != '0)) begin
                hit[i] = (sb_rd_q[i] == rs1_i) ||
                         (use_rs2_i && (sb_rd_q[i] == rs2_i));
            end
        end
    end

    assign hazard_o = |hit;
    assign empty_o  = ~|sb_v_q;

endmodule

// File: rtl/pipe_issue_ctrl.sv
// Issue controller between fetch and the S1 decode register. Passes the
// fetched instruction into S1 or injects a NOP bubble on RAW hazards and
// while draining/holding for a halt request; counts hazard-bubble cycles.
module pipe_issue_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int RSEL_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic       clk,
    input  logic       rst,
    pipe_issue_if.slave pif
);

    issue_state_e     state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [RSEL_W-1:0] rd, rs1, rs2;
    logic              use_rs2;
    logic              sb_hit, sb_empty;
    logic              hazard;
    logic              can_issue_state;
    logic              issue;
    logic              count_en;

    assign rd      = pif.InstrIn[RD_LSB  +: RSEL_W];
    assign rs1     = pif.InstrIn[RS1_LSB +: RSEL_W];
    assign rs2     = pif.InstrIn[RS2_LSB +: RSEL_W];
    assign use_rs2 = uses_rs2(pif.InstrIn);

    hazard_scoreboard #(
        .DEPTH  (DEPTH),
        .RSEL_W (RSEL_W)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .rs1_i     (rs1),
        .rs2_i     (rs2),
        .use_rs2_i (use_rs2),
        .push_v_i  (issue & pif.instr_we & (rd != '0)),
        .push_rd_i (rd),
        .hazard_o  (sb_hit),
        .empty_o   (sb_empty)
    );

    assign hazard          = pif.instr_valid & sb_hit;
    assign can_issue_state = (state_q == ST_RUN) || (state_q == ST_STALL);
    // Halt beats issue; reset forces a bubble even before the state settles.
    assign issue    = rst & can_issue_state & pif.instr_valid & ~hazard & ~pif.halt_req;
    assign count_en = hazard & can_issue_state;

    assign pif.instr_ready     = issue;
    assign pif.s1_instr        = issue ? pif.InstrIn : NOP_INSTR;
    assign pif.s1_write_enable = issue & pif.instr_we;
    assign pif.stall_count     = stall_cnt_q;
    assign pif.halted          = (state_q == ST_HALTED);

    // State register for the issue FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_RUN;
        else      state_q <= state_d;
    end

    // Next-state: stall on hazard, drain on halt, hold halted until released.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (pif.halt_req)  state_d = ST_HALTING;
                else if (hazard)   state_d = ST_STALL;
            end
            ST_STALL: begin
                if (pif.halt_req)  state_d = ST_HALTING;
                else if (!hazard)  state_d = ST_RUN;
            end
            ST_HALTING: begin
                if (sb_empty)      state_d = ST_HALTED;
            end
            ST_HALTED: begin
                if (!pif.halt_req) state_d = ST_RUN;
            end
            default:               state_d = ST_RUN;
        endcase
    end

    // Saturating hazard-bubble counter: sticks at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (count_en && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_cnt_q <= '0;
        else      stall_cnt_q <= stall_cnt_d;
    end

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Bench for pipe_issue_ctrl: a hand-derived vector table plus short
// multi-cycle sequences; each driven cycle queues its expected outputs and
// a negedge monitor pops and compares. A second CNT_W=4 instance shares the
// stimulus to exercise counter saturation.
module tb_pipe_issue_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_issue_if #(.CNT_W(16)) pif ();
    pipe_issue_if #(.CNT_W(4))  pif4 ();

    assign pif4.InstrIn     = pif.InstrIn;
    assign pif4.instr_valid = pif.instr_valid;
    assign pif4.instr_we    = pif.instr_we;
    assign pif4.halt_req    = pif.halt_req;

    pipe_issue_ctrl #(.DEPTH(3), .RSEL_W(5), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .pif(pif));
    pipe_issue_ctrl #(.DEPTH(3), .RSEL_W(5), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .pif(pif4));

    typedef struct {
        logic        rst_n;
        logic        valid;
        logic        we;
        logic        halt;
        logic [31:0] instr;
        logic        exp_ready;
        logic        exp_halted;
        int          exp_cnt;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_vec = 0;

    function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2,
                                       input logic ds, input int tag);
        logic [31:0] w;
        w        = 32'h0;
        w[29]    = ds;
        w[25:21] = rd[4:0];
        w[20:16] = rs1[4:0];
        w[15:11] = rs2[4:0];
        w[10:0]  = tag[10:0];
        return w;
    endfunction

    function automatic vec_t V(input logic r, input logic v, input logic we, input logic h,
                               input logic [31:0] ins, input logic rdy, input logic hlt,
                               input int cnt);
        vec_t x;
        x.rst_n = r; x.valid = v; x.we = we; x.halt = h; x.instr = ins;
        x.exp_ready = rdy; x.exp_halted = hlt; x.exp_cnt = cnt;
        return x;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        rst             = v.rst_n;
        pif.instr_valid = v.valid;
        pif.instr_we    = v.we;
        pif.halt_req    = v.halt;
        pif.InstrIn     = v.instr;
        exp_q.push_back(v);
    endtask

    // Compare the queued expectation against the DUT mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            vec_t e;
            int   c4;
            e  = exp_q.pop_front();
            c4 = (e.exp_cnt > 15) ? 15 : e.exp_cnt;
            chk("instr_ready", n_vec, 32'(pif.instr_ready), 32'(e.exp_ready));
            chk("s1_instr", n_vec, pif.s1_instr, e.exp_ready ? e.instr : 32'h0);
            chk("s1_write_enable", n_vec, 32'(pif.s1_write_enable), 32'(e.exp_ready & e.we));
            chk("halted", n_vec, 32'(pif.halted), 32'(e.exp_halted));
            chk("stall_count", n_vec, 32'(pif.stall_count), 32'(e.exp_cnt));
            chk("stall_count_w4", n_vec, 32'(pif4.stall_count), 32'(c4));
            n_vec++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        rst = 1'b0;
        pif.instr_valid = 1'b0;
        pif.instr_we    = 1'b0;
        pif.halt_req    = 1'b0;
        pif.InstrIn     = 32'h0;

        // reset state with a valid candidate present
        tbl.push_back(V(0, 1, 1, 0, mk(1, 0, 0, 0, 11'h001), 0, 0, 0));
        // independent stream: no bubbles
        tbl.push_back(V(1, 1, 1, 0, mk(1, 0, 0, 0, 11'h011), 1, 0, 0));
        tbl.push_back(V(1, 1, 1, 0, mk(2, 0, 0, 0, 11'h012), 1, 0, 0));
        tbl.push_back(V(1, 1, 1, 0, mk(3, 0, 0, 0, 11'h013), 1, 0, 0));
        // idle cycles: bubble, no count
        tbl.push_back(V(1, 0, 0, 0, mk(3, 3, 3, 0, 11'h020), 0, 0, 0));
        tbl.push_back(V(1, 0, 0, 0, mk(3, 3, 3, 0, 11'h021), 0, 0, 0));
        tbl.push_back(V(1, 0, 0, 0, mk(3, 3, 3, 0, 11'h022), 0, 0, 0));
        // rd=5 producer, rs1=5 consumer: 3 bubbles then issue
        tbl.push_back(V(1, 1, 1, 0, mk(5, 0, 0, 0, 11'h030), 1, 0, 0));
        tbl.push_back(V(1, 1, 0, 0, mk(0, 5, 0, 0, 11'h031), 0, 0, 0));
        tbl.push_back(V(1, 1, 0, 0, mk(0, 5, 0, 0, 11'h031), 0, 0, 1));
        tbl.push_back(V(1, 1, 0, 0, mk(0, 5, 0, 0, 11'h031), 0, 0, 2));
        tbl.push_back(V(1, 1, 0, 0, mk(0, 5, 0, 0, 11'h031), 1, 0, 3));
        // rd=7 then rs2=7 with immediate operand: no stall
        tbl.push_back(V(1, 1, 1, 0, mk(7, 0, 0, 0, 11'h040), 1, 0, 3));
        tbl.push_back(V(1, 1, 0, 0, mk(0, 0, 7, 1, 11'h041), 1, 0, 3));
        // rd=7 then rs2=7 register operand: 3 bubbles
        tbl.push_back(V(1, 1, 1, 0, mk(7, 0, 0, 0, 11'h042), 1, 0, 3));
        tbl.push_back(V(1, 1, 0, 0, mk(0, 0, 7, 0, 11'h043), 0, 0, 3));
        tbl.push_back(V(1, 1, 0, 0, mk(0, 0, 7, 0, 11'h043), 0, 0, 4));
        tbl.push_back(V(1, 1, 0, 0, mk(0, 0, 7, 0, 11'h043), 0, 0, 5));
        tbl.push_back(V(1, 1, 0, 0, mk(0, 0, 7, 0, 11'h043), 1, 0, 6));
        // rd=0 producer followed by r0 consumer: no stall
        tbl.push_back(V(1, 1, 1, 0, mk(0, 0, 0, 0, 11'h050), 1, 0, 6));
        tbl.push_back(V(1, 1, 0, 0, mk(1, 0, 0, 0, 11'h051), 1, 0, 6));
        // two writers in flight, then halt: drain, halt, release
        tbl.push_back(V(1, 1, 1, 0, mk(9,  0, 0, 0, 11'h060), 1, 0, 6));
        tbl.push_back(V(1, 1, 1, 0, mk(10, 0, 0, 0, 11'h061), 1, 0, 6));
        tbl.push_back(V(1, 1, 1, 1, mk(11, 0, 0, 0, 11'h062), 0, 0, 6));
        tbl.push_back(V(1, 1, 1, 1, mk(11, 0, 0, 0, 11'h062), 0, 0, 6));
        tbl.push_back(V(1, 1, 1, 1, mk(11, 0, 0, 0, 11'h062), 0, 0, 6));
        tbl.push_back(V(1, 1, 1, 1, mk(11, 0, 0, 0, 11'h062), 0, 0, 6));
        tbl.push_back(V(1, 1, 1, 1, mk(11, 0, 0, 0, 11'h062), 0, 1, 6));
        tbl.push_back(V(1, 1, 1, 0, mk(11, 0, 0, 0, 11'h062), 0, 1, 6));
        tbl.push_back(V(1, 1, 1, 0, mk(11, 0, 0, 0, 11'h062), 1, 0, 6));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // repeated producer/consumer pairs push the 4-bit counter past saturation
        c = 6;
        for (int r = 0; r < 5; r++) begin
            step(V(1, 1, 1, 0, mk(20, 0, 0, 0, 11'h100 + r), 1, 0, c));
            for (int b = 0; b < 3; b++)
                step(V(1, 1, 0, 0, mk(0, 20, 0, 0, 11'h180 + r), 0, 0, c + b));
            c = c + 3;
            step(V(1, 1, 0, 0, mk(0, 20, 0, 0, 11'h180 + r), 1, 0, c));
        end

        // fill the scoreboard, enter STALL, then reset mid-stall
        step(V(1, 1, 1, 0, mk(12, 0, 0, 0, 11'h200), 1, 0, c));
        step(V(1, 1, 1, 0, mk(13, 0, 0, 0, 11'h201), 1, 0, c));
        step(V(1, 1, 1, 0, mk(14, 0, 0, 0, 11'h202), 1, 0, c));
        step(V(1, 1, 0, 0, mk(0, 14, 0, 0, 11'h203), 0, 0, c));
        step(V(1, 1, 0, 0, mk(0, 14, 0, 0, 11'h203), 0, 0, c + 1));
        step(V(0, 1, 0, 0, mk(0, 14, 0, 0, 11'h203), 0, 0, 0));
        // scoreboard cleared: the former consumer now issues at once
        step(V(1, 1, 0, 0, mk(0, 14, 0, 0, 11'h203), 1, 0, 0));
        step(V(1, 1, 1, 0, mk(15, 0, 0, 0, 11'h204), 1, 0, 0));

        for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
